// File: rtl/cvo_loopback_capture.sv
// rtl/cvo_loopback_capture.sv - clocked-video receive side re-packetised into Avalon-ST Video
// Captures the ITC output for the loopback self-test and measures frame geometry.
module cvo_loopback_capture #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12,
  parameter bit SYNC_NEG   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [CNT_W-1:0]  width,
  output logic [CNT_W-1:0]  height,
  output logic [15:0]       frame_count,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WW-1:0] HDR_WORD = {2'b10, {DATA_W{1'b0}}};
  localparam logic [WW-1:0] EOP_ZERO = {2'b01, {DATA_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT_VS, ACTIVE, DROP, TERM} state_t;
  state_t state;

  logic [DATA_W-1:0] in_data;
  logic in_dv, in_hs, in_vs, dv_q, hs_q, vs_q;
  logic vs_edge, hs_edge, dv_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_data <= '0;
      in_dv   <= 1'b0;
      in_hs   <= 1'b0;
      in_vs   <= 1'b0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      in_data <= vid_data;
      in_dv   <= vid_datavalid;
      in_hs   <= vid_h_sync ^ SYNC_NEG;
      in_vs   <= vid_v_sync ^ SYNC_NEG;
      dv_q    <= in_dv;
      hs_q    <= in_hs;
      vs_q    <= in_vs;
    end
  end

  assign vs_edge = in_vs & ~vs_q;
  assign hs_edge = in_hs & ~hs_q;
  assign dv_fall = dv_q & ~in_dv;

  // Output FIFO: {sop, eop, data}, show-ahead, extra pointer bit tells full from empty.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, wr, drop;
  logic          push_en;
  logic [WW-1:0] push_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && dout_ready;
  assign wr    = push_en && (!full || pop);
  assign drop  = push_en && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign dout_valid = !empty;
  assign {dout_sop, dout_eop, dout_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

  logic [CNT_W-1:0] line_cnt, line_total;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_cnt   <= '0;
      line_total <= '0;
      width      <= '0;
    end else if (state == IDLE) begin
      line_cnt   <= '0;
      line_total <= '0;
    end else begin
      if (dv_fall) begin
        width    <= line_cnt;
        line_cnt <= '0;
        if (line_total != CNT_MAX) line_total <= line_total + 1'b1;
      end else if (in_dv) begin
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
      end else if (hs_edge) begin
        line_cnt <= '0;
      end
      if (vs_edge) line_total <= '0;
    end
  end

  logic [DATA_W-1:0] pend_data;
  logic              pend_valid, hdr_pend;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pend_data   <= '0;
      pend_valid  <= 1'b0;
      hdr_pend    <= 1'b0;
      push_en     <= 1'b0;
      push_word   <= '0;
      frame_count <= '0;
      height      <= '0;
      overflow    <= 1'b0;
    end else begin
      push_en   <= 1'b0;
      push_word <= '0;
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      // A dropped word leaves the packet corrupt, so abandon it outright.
      if (drop) begin
        state      <= DROP;
        pend_valid <= 1'b0;
        hdr_pend   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (enable) state <= WAIT_VS;
          WAIT_VS: if (vs_edge) begin
            if (enable) begin
              push_en   <= 1'b1;
              push_word <= HDR_WORD;
              state     <= ACTIVE;
            end else begin
              state <= IDLE;
            end
          end
          ACTIVE: if (vs_edge) begin
            push_en     <= 1'b1;
            push_word   <= {2'b01, {DATA_W{pend_valid}} & pend_data};
            pend_valid  <= 1'b0;
            frame_count <= frame_count + 1'b1;
            height      <= line_total;
            if (enable) hdr_pend <= 1'b1;
            else state <= IDLE;
          end else begin
            if (hdr_pend) begin
              push_en   <= 1'b1;
              push_word <= HDR_WORD;
              hdr_pend  <= 1'b0;
            end else if (in_dv && pend_valid) begin
              push_en   <= 1'b1;
              push_word <= {2'b00, pend_data};
            end
            if (in_dv) begin
              pend_data  <= in_data;
              pend_valid <= 1'b1;
            end
          end
          DROP: if (vs_edge) state <= TERM;
          TERM: if (!full) begin
            push_en   <= 1'b1;
            push_word <= EOP_ZERO;
            state     <= WAIT_VS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cvo_loopback_capture.sv
// tb/tb_cvo_loopback_capture.sv - scoreboard bench for cvo_loopback_capture
// Drives both sync polarities in parallel; one instance sees inverted sync pins.
module tb_cvo_loopback_capture;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 12;
  localparam int WW     = DATA_W + 2;
  localparam logic [WW-1:0] HDR  = {2'b10, 24'h0};
  localparam logic [WW-1:0] EOP0 = {2'b01, 24'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, enable, dv, vs_act, hs_act, clr_overflow;
  logic [DATA_W-1:0] data;
  logic [1:0] rdy_mode;
  logic [1:0] tcnt = 2'd0;
  logic dout_ready;

  always @(posedge clk) tcnt <= (tcnt == 2'd2) ? 2'd0 : tcnt + 2'd1;
  assign dout_ready = (rdy_mode == 2'd0) ? 1'b1 : (rdy_mode == 2'd1) ? 1'b0 : (tcnt == 2'd0);

  logic [DATA_W-1:0] dout_data, p_data;
  logic dout_valid, dout_sop, dout_eop, overflow;
  logic p_valid, p_sop, p_eop, p_overflow;
  logic [CNT_W-1:0] width, height, p_width, p_height;
  logic [15:0] frame_count, p_frame_count;

  cvo_loopback_capture #(.SYNC_NEG(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .vid_data(data), .vid_datavalid(dv), .vid_h_sync(~hs_act), .vid_v_sync(~vs_act),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .width(width), .height(height),
    .frame_count(frame_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  cvo_loopback_capture #(.SYNC_NEG(1'b0)) u_pos (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .vid_data(data), .vid_datavalid(dv), .vid_h_sync(hs_act), .vid_v_sync(vs_act),
    .dout_data(p_data), .dout_valid(p_valid), .dout_ready(dout_ready),
    .dout_sop(p_sop), .dout_eop(p_eop), .width(p_width), .height(p_height),
    .frame_count(p_frame_count), .overflow(p_overflow), .clr_overflow(clr_overflow)
  );

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] q1[$];
  logic [WW-1:0] q2[$];
  bit open_pkt = 0;
  bit px_in_pkt = 0;
  int rec_left = -1;
  logic [15:0] exp_fc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid && dout_ready) begin
        checks++;
        assert (q1.size() > 0) else begin
          errors++;
          $error("FAIL neg_extra_word observed=%0h expected=none", {dout_sop, dout_eop, dout_data});
        end
        if (q1.size() > 0) chk("neg_word", {dout_sop, dout_eop, dout_data}, q1.pop_front());
      end else if (!dout_valid) begin
        chk("neg_idle_zero", {dout_sop, dout_eop, dout_data}, 0);
      end
      if (p_valid && dout_ready) begin
        checks++;
        assert (q2.size() > 0) else begin
          errors++;
          $error("FAIL pos_extra_word observed=%0h expected=none", {p_sop, p_eop, p_data});
        end
        if (q2.size() > 0) chk("pos_word", {p_sop, p_eop, p_data}, q2.pop_front());
      end else if (!p_valid) begin
        chk("pos_idle_zero", {p_sop, p_eop, p_data}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_exp(input logic [WW-1:0] w);
    q1.push_back(w);
    q2.push_back(w);
  endtask

  task automatic px(input int n, input int base, input bit rec);
    for (int i = 0; i < n; i++) begin
      dv = 1'b1;
      data = DATA_W'(base + i);
      if (rec && rec_left != 0) begin
        push_exp({2'b00, data});
        px_in_pkt = 1;
        if (rec_left > 0) rec_left--;
      end
      step();
    end
  endtask

  task automatic line(input int n, input int base, input bit rec);
    px(n, base, rec);
    dv = 1'b0;
    data = '0;
    idle(2);
    hs_act = 1'b1;
    idle(2);
    hs_act = 1'b0;
    idle(2);
  endtask

  task automatic frame(input int w, input int h, input int base, input bit rec);
    for (int l = 0; l < h; l++) line(w, base + l * 16, rec);
  endtask

  task automatic vs_pulse();
    vs_act = 1'b1;
    idle(3);
    vs_act = 1'b0;
    idle(4);
  endtask

  // Models the capture FSM at a frame edge: close any open packet, then open a new one if enabled.
  task automatic vs_frame_edge();
    logic [WW-1:0] w;
    if (open_pkt) begin
      if (px_in_pkt) begin
        w = q1.pop_back(); w[DATA_W] = 1'b1; q1.push_back(w);
        w = q2.pop_back(); w[DATA_W] = 1'b1; q2.push_back(w);
      end else begin
        push_exp(EOP0);
      end
      exp_fc++;
    end
    if (enable) begin
      push_exp(HDR);
      open_pkt = 1;
    end else begin
      open_pkt = 0;
    end
    px_in_pkt = 0;
    vs_pulse();
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    idle(2);
    chk("drain_neg", q1.size(), 0);
    chk("drain_pos", q2.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {dout_valid, p_valid}, 0);
    chk({tag, "_word"}, {dout_sop, dout_eop, dout_data, p_sop, p_eop, p_data}, 0);
    chk({tag, "_width"}, {width, p_width}, 0);
    chk({tag, "_height"}, {height, p_height}, 0);
    chk({tag, "_fc"}, {frame_count, p_frame_count}, 0);
    chk({tag, "_ovf"}, {overflow, p_overflow}, 0);
  endtask

  task automatic chk_geom(input string tag, input int w, input int h);
    chk({tag, "_width"}, width, w);
    chk({tag, "_height"}, height, h);
    chk({tag, "_fc"}, frame_count, exp_fc);
    chk({tag, "_pos_width"}, p_width, w);
    chk({tag, "_pos_height"}, p_height, h);
    chk({tag, "_pos_fc"}, p_frame_count, exp_fc);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; dv = 1'b0; data = '0;
    vs_act = 1'b0; hs_act = 1'b0; clr_overflow = 1'b0; rdy_mode = 2'd0;
    idle(3);
    @(negedge clk);
    chk_all_zero("reset");
    step();
    reset_n = 1'b1;
    enable = 1'b1;
    idle(4);

    // Basic 4x2 frames
    vs_frame_edge();
    frame(4, 2, 24'h100, 1);
    vs_frame_edge();
    frame(4, 2, 24'h200, 1);
    vs_frame_edge();
    wait_drain(100);
    chk_geom("basic", 4, 2);
    chk("basic_ovf", {overflow, p_overflow}, 0);

    // Sink ready one cycle in three
    rdy_mode = 2'd2;
    frame(4, 2, 24'hA50, 1);
    vs_frame_edge();
    wait_drain(200);
    rdy_mode = 2'd0;
    chk_geom("throttle", 4, 2);
    chk("throttle_ovf", {overflow, p_overflow}, 0);

    // Enable dropped mid-frame: packet completes, no new header
    line(4, 24'h300, 1);
    enable = 1'b0;
    line(4, 24'h310, 1);
    vs_frame_edge();
    wait_drain(100);
    chk_geom("disable", 4, 2);
    line(4, 24'h320, 0);
    vs_frame_edge();
    wait_drain(50);
    chk("idle_no_output", {dout_valid, p_valid}, 0);
    chk("idle_fc", frame_count, exp_fc);

    // Overflow with sink stalled, 20-pixel frame
    enable = 1'b1;
    idle(3);
    rdy_mode = 2'd1;
    vs_frame_edge();
    rec_left = 15;
    line(20, 24'h400, 1);
    rec_left = -1;
    chk("ovf_set", {overflow, p_overflow}, 2'b11);
    vs_pulse();
    push_exp(EOP0);
    open_pkt = 0;
    px_in_pkt = 0;
    rdy_mode = 2'd0;
    wait_drain(100);
    chk("ovf_sticky", {overflow, p_overflow}, 2'b11);
    frame(4, 2, 24'h500, 0);
    vs_frame_edge();
    frame(4, 2, 24'h600, 1);
    vs_frame_edge();
    wait_drain(100);
    chk_geom("after_ovf", 4, 2);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    idle(1);
    chk("ovf_cleared", {overflow, p_overflow}, 0);

    // Reset pulse mid-frame
    px(3, 24'h700, 1);
    dv = 1'b0;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    chk_all_zero("midreset");
    q1.delete();
    q2.delete();
    open_pkt = 0;
    px_in_pkt = 0;
    exp_fc = '0;
    step();
    reset_n = 1'b1;
    idle(4);
    vs_frame_edge();
    frame(4, 2, 24'h800, 1);
    vs_frame_edge();
    wait_drain(100);
    chk_geom("resume", 4, 2);

    // Long line saturates the width counter
    line(4100, 24'h10000, 1);
    chk("sat_width", {width, p_width}, {12'd4095, 12'd4095});
    vs_frame_edge();
    wait_drain(300);
    chk_geom("sat", 4095, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
